// File: rtl/seq_multiplier_pkg.sv
// Shared types and sizing helpers for the sequential multiplier.
// Build option: define SEQ_MULTIPLIER_RADIX4_EN to retire 2 multiplier bits per cycle.
// Without it the datapath is radix-2, one bit per cycle.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef SEQ_MULTIPLIER_RADIX4_EN
    localparam bit RADIX4_EN  = 1'b1;
`else
    localparam bit RADIX4_EN  = 1'b0;
`endif

    localparam int RADIX_BITS = RADIX4_EN ? 2 : 1;

    // Number of CALC iterations needed to consume every multiplier bit.
    function automatic int calc_iters(input int width, input bit radix4);
        return radix4 ? (width / 2) : width;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface seq_multiplier_if #(
    parameter int WIDTH = 24
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   signed_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/seq_multiplier_step.sv
// One shift-add iteration, MSB-first: acc_next = (acc << r) + bits * mag.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
import seq_multiplier_pkg::*;

module seq_multiplier_step #(
    parameter int WIDTH = 24
) (
    input  logic [2*WIDTH-1:0]     acc,
    input  logic [WIDTH-1:0]       mag,
`ifdef SEQ_MULTIPLIER_RADIX4_EN
    input  logic [WIDTH+1:0]       mag3,
`endif
    input  logic [RADIX_BITS-1:0]  bits,
    output logic [2*WIDTH-1:0]     acc_next
);

`ifdef SEQ_MULTIPLIER_RADIX4_EN
    logic [WIDTH+1:0] multiple;

    // Select 0/1/2/3 x magnitude; 3x comes precomputed so no adder sits here.
    always_comb begin
        multiple = '0;
        case (bits)
            2'd1:    multiple = {2'b00, mag};
            2'd2:    multiple = {1'b0, mag, 1'b0};
            2'd3:    multiple = mag3;
            default: multiple = '0;
        endcase
        acc_next = {acc[2*WIDTH-3:0], 2'b00} + {{(WIDTH-2){1'b0}}, multiple};
    end
`else
    // Single-bit shift-add.
    always_comb begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
        if (bits[0])
            acc_next = acc_next + {{WIDTH{1'b0}}, mag};
    end
`endif

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH (WIDTH even, >= 4).
// Latency: result valid N cycles after accept (N = WIDTH, or WIDTH/2 with SEQ_MULTIPLIER_RADIX4_EN).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
import seq_multiplier_pkg::*;

module seq_multiplier #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    seq_multiplier_if.slave  bus
);

    localparam int N  = calc_iters(WIDTH, RADIX4_EN);
    localparam int CW = $clog2(N + 1);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mult;
    logic                   neg;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     acc_next;
    logic [WIDTH-1:0]       a_mag_in;
    logic [WIDTH-1:0]       b_mag_in;
`ifdef SEQ_MULTIPLIER_RADIX4_EN
    logic [WIDTH+1:0]       mag3;
`endif

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        a_mag_in = bus.a;
        b_mag_in = bus.b;
        if (bus.signed_mode && bus.a[WIDTH-1])
            a_mag_in = ~bus.a + 1'b1;
        if (bus.signed_mode && bus.b[WIDTH-1])
            b_mag_in = ~bus.b + 1'b1;
    end

    seq_multiplier_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .mag      (mag_a),
`ifdef SEQ_MULTIPLIER_RADIX4_EN
        .mag3     (mag3),
`endif
        .bits     (mult[WIDTH-1 -: RADIX_BITS]),
        .acc_next (acc_next)
    );

    // Control FSM plus datapath registers; the sign is applied once on the way into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            mag_a         <= '0;
            mult          <= '0;
            neg           <= 1'b0;
            acc           <= '0;
`ifdef SEQ_MULTIPLIER_RADIX4_EN
            mag3          <= '0;
`endif
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_a        <= a_mag_in;
                        mult         <= b_mag_in;
                        neg          <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifdef SEQ_MULTIPLIER_RADIX4_EN
                        mag3         <= {2'b00, a_mag_in} + {1'b0, a_mag_in, 1'b0};
`endif
                        acc          <= '0;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    mult <= mult << RADIX_BITS;
                    if (cnt == CW'(N - 1)) begin
                        bus.result    <= neg ? (~acc_next + 1'b1) : acc_next;
                        bus.out_valid <= 1'b1;
                        cnt           <= '0;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 24: operand width in bits; SHALL be even and at least 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 signed_mode  input  1  1: a and b are two's complement; 0: both unsigned.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  2*WIDTH  product.

Function
REQ-012 States SHALL be IDLE, CALC and DONE; no other states.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept: in IDLE with in_valid=1, a, b and signed_mode SHALL be captured and the state SHALL move to CALC.
REQ-015 Input changes after acceptance SHALL NOT affect the in-flight result.
REQ-016 CALC SHALL run N iterations: N=WIDTH in radix-2, N=WIDTH/2 in radix-4 (REQ-027).
REQ-017 Latency: acceptance at edge k SHALL give out_valid=1 after edge k+N.
REQ-018 Arithmetic: signed_mode=1 gives result = a*b signed, full 2*WIDTH bits; signed_mode=0 gives the unsigned product; there SHALL be no overflow or truncation.
REQ-019 Signed handling: operand magnitudes SHALL be formed at capture, and the product SHALL be conditionally negated when the state moves to DONE.
REQ-020 The most-negative operand (-2^(WIDTH-1)) SHALL produce the correct result.
REQ-021 DONE: result and out_valid SHALL hold stable until out_ready=1; out_valid&out_ready SHALL move the state to IDLE.
REQ-022 There SHALL be no overlap: a new operand pair SHALL be accepted no earlier than the cycle after the handshake.
REQ-023 in_valid during CALC or DONE SHALL be ignored (not queued).
REQ-024 result SHALL hold its last value in IDLE and CALC; only the CALC-to-DONE transition SHALL update it.

Reset
REQ-025 On rst=1 at a clock edge: state SHALL go to IDLE, out_valid=0, in_ready=1, result=0, iteration counter=0.
REQ-026 rst during CALC or DONE SHALL abandon the operation; no out_valid pulse SHALL follow.

Configuration
REQ-027 Macro SEQ_MULTIPLIER_RADIX4_EN: when defined, CALC SHALL retire 2 multiplier bits per cycle using a 0/1/2/3 x multiple table (3x precomputed at capture), N=WIDTH/2; when undefined, radix-2 shift-add with N=WIDTH; results SHALL be identical in both builds.

Structure
REQ-028 Package seq_multiplier_pkg SHALL hold the state enum (IDLE/CALC/DONE) and a function computing N from WIDTH and the radix.
REQ-029 One sub-module, seq_multiplier_step, SHALL be combinational: accumulator, magnitude, current multiplier bits in; next accumulator out.
REQ-030 The iteration counter SHALL be $clog2(N+1) bits wide.

Verification
REQ-031 WIDTH=24, unsigned, a=b=0xFFFFFF: result=0xFFFFFE000001, out_valid exactly 24 cycles after accept (12 with the radix-4 macro).
REQ-032 Signed, a=b=0xFFFFFF (-1): result=0x000000000001.
REQ-033 Signed, a=0x800000, b=0x000001: result=0xFFFFFF800000; a=b=0x800000: result=0x400000000000.
REQ-034 Hold out_ready=0 for 5 cycles in DONE: result and out_valid stable, in_ready=0, a pulsed in_valid ignored; the handshake then gives in_ready=1 next cycle.
REQ-035 Assert rst at CALC iteration 10: next cycle in_ready=1, out_valid=0, result=0; a new pair of 3*5 unsigned gives 15.
REQ-036 10k random pairs, random signed_mode, random out_ready stalls: every result matches a reference product in both macro builds.
